// File: rtl/wb_reg_bank_pkg.sv
// Shared types and widths for the wb_reg_bank register slave.
// Holds the FSM state encoding and the byte-lane merge helper.
package wb_reg_bank_pkg;

  localparam int WORD_W    = 32;
  localparam int SEL_W     = 4;
  localparam int ACK_DLY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [WORD_W-1:0] laneMerge(
    input logic [WORD_W-1:0] oldWord,
    input logic [WORD_W-1:0] newWord,
    input logic [SEL_W-1:0]  sel
  );
    logic [WORD_W-1:0] merged;
    merged = oldWord;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_reg_bank_if.sv
// STB/WE/ACK peripheral bus bundle; the master drives requests, the slave returns completions.
interface wb_reg_bank_if;
  import wb_reg_bank_pkg::*;

  logic [WORD_W-1:0] iADR;
  logic [WORD_W-1:0] iDAT;
  logic [SEL_W-1:0]  iSEL;
  logic              iWE;
  logic              iSTB;
  logic [WORD_W-1:0] oDAT;
  logic              oACK;
  logic              oERR;

  modport master (
    output iADR, iDAT, iSEL, iWE, iSTB,
    input  oDAT, oACK, oERR
  );

  modport slave (
    input  iADR, iDAT, iSEL, iWE, iSTB,
    output oDAT, oACK, oERR
  );

endinterface

// File: rtl/wb_reg_bank_byte_reg.sv
// wb_byte_reg: one 32-bit control word with per-byte write enables and a parametrised reset value.
module wb_byte_reg
  import wb_reg_bank_pkg::*;
#(
  parameter logic [WORD_W-1:0] RST_VAL = '0
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iWE,
  input  logic [SEL_W-1:0]  iSEL,
  input  logic [WORD_W-1:0] iDAT,
  output logic [WORD_W-1:0] oQ
);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)  oQ <= RST_VAL;
    else if (iWE) oQ <= laneMerge(oQ, iDAT, iSEL);
  end

endmodule

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: NUM_RO read-only ID words plus NUM_RW byte-writable control words behind a bus window.
// Define WB_REG_BANK_ACCNT_EN to map an ack-counter word right after the RW words.
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter logic [31:0]               BASE_ADDR = 32'h0200_0100,
  parameter int                        WIN_AW    = 8,
  parameter int                        NUM_RO    = 3,
  parameter int                        NUM_RW    = 4,
  parameter logic [NUM_RO*WORD_W-1:0]  RO_INIT   = {32'h0001_0003, 32'h0001_0002, 32'h0001_0001},
  parameter logic [NUM_RW*WORD_W-1:0]  RW_INIT   = '0,
  parameter int                        ACK_DLY   = 0
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  wb_reg_bank_if.slave             bus,
  output logic [NUM_RW*WORD_W-1:0] oREG
);

`ifdef WB_REG_BANK_ACCNT_EN
  localparam int ACC_WORDS = 1;
`else
  localparam int ACC_WORDS = 0;
`endif
  localparam int                   NUM_WORDS = NUM_RO + NUM_RW + ACC_WORDS;
  localparam logic [31:0]          WIN_MASK  = 32'((64'd1 << WIN_AW) - 64'd1);
  localparam logic [ACK_DLY_W-1:0] WAIT_LAST = ACK_DLY_W'(ACK_DLY - 1);

  state_t                state;
  logic [ACK_DLY_W-1:0]  waitCnt;
  logic [WIN_AW-1:0]     offQ;
  logic [WORD_W-1:0]     datQ;
  logic [SEL_W-1:0]      selQ;
  logic                  weQ;
  logic                  errQ;
  logic [WORD_W-1:0]     datR;
  logic                  ackR;
  logic                  errR;

  logic                  hit;
  logic [WIN_AW-1:0]     decOff;
  logic                  decWe;
  int                    decIdx;
  logic                  decErr;
  logic [WORD_W-1:0]     rdWord;
  logic                  wrHit;
  int                    wrIdx;
  logic [WORD_W-1:0]     rwQ [NUM_RW];
`ifdef WB_REG_BANK_ACCNT_EN
  logic [WORD_W-1:0]     ackCnt;
`endif

  assign hit = (bus.iADR & ~WIN_MASK) == BASE_ADDR;

  // The response is computed on the edge entering RESP: from the live bus when ACK_DLY=0, else from the latch.
  always_comb begin
    decOff = (state == IDLE) ? bus.iADR[WIN_AW-1:0] : offQ;
    decWe  = (state == IDLE) ? bus.iWE : weQ;
    decIdx = int'(decOff[WIN_AW-1:2]);
    decErr = (decOff[1:0] != 2'b00) || (decIdx >= NUM_WORDS) ||
             (decWe && ((decIdx < NUM_RO) || (decIdx >= NUM_RO + NUM_RW)));
    rdWord = '0;
    for (int k = 0; k < NUM_RO; k++) begin
      if (decIdx == k) rdWord = RO_INIT[WORD_W*k +: WORD_W];
    end
    for (int k = 0; k < NUM_RW; k++) begin
      if (decIdx == NUM_RO + k) rdWord = rwQ[k];
    end
`ifdef WB_REG_BANK_ACCNT_EN
    if (decIdx == NUM_RO + NUM_RW) rdWord = ackCnt;
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      offQ    <= '0;
      datQ    <= '0;
      selQ    <= '0;
      weQ     <= 1'b0;
      errQ    <= 1'b0;
      datR    <= '0;
      ackR    <= 1'b0;
      errR    <= 1'b0;
    end else begin
      ackR <= 1'b0;
      errR <= 1'b0;
      datR <= '0;
      case (state)
        IDLE: begin
          if (bus.iSTB && hit) begin
            offQ    <= bus.iADR[WIN_AW-1:0];
            datQ    <= bus.iDAT;
            selQ    <= bus.iSEL;
            weQ     <= bus.iWE;
            waitCnt <= '0;
            if (ACK_DLY == 0) begin
              state <= RESP;
              ackR  <= !decErr;
              errR  <= decErr;
              errQ  <= decErr;
              datR  <= decErr ? '0 : rdWord;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (waitCnt == WAIT_LAST) begin
            state <= RESP;
            ackR  <= !decErr;
            errR  <= decErr;
            errQ  <= decErr;
            datR  <= decErr ? '0 : rdWord;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        RESP:    state <= HOLD;
        HOLD:    if (!bus.iSTB) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes commit at the edge closing RESP, so a reset during WAIT discards them.
  assign wrHit = (state == RESP) && weQ && !errQ;
  assign wrIdx = int'(offQ[WIN_AW-1:2]);

  for (genvar k = 0; k < NUM_RW; k++) begin : gRw
    wb_byte_reg #(
      .RST_VAL(RW_INIT[WORD_W*k +: WORD_W])
    ) uReg (
      .iCLK  (iCLK),
      .iRST_n(iRST_n),
      .iWE   (wrHit && (wrIdx == NUM_RO + k)),
      .iSEL  (selQ),
      .iDAT  (datQ),
      .oQ    (rwQ[k])
    );
    assign oREG[WORD_W*k +: WORD_W] = rwQ[k];
  end

`ifdef WB_REG_BANK_ACCNT_EN
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)                   ackCnt <= '0;
    else if (state == RESP && ackR) ackCnt <= ackCnt + 1'b1;
  end
`endif

  assign bus.oDAT = datR;
  assign bus.oACK = ackR;
  assign bus.oERR = errR;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed bench for wb_reg_bank: one instance with ACK_DLY=0 and one with ACK_DLY=3.
module tb_wb_reg_bank;

  logic        clk = 1'b0;
  logic        rstN;
  logic [127:0] reg0;
  logic [127:0] reg3;
  int          nTests = 0;
  int          nFail  = 0;

  wb_reg_bank_if bus0 ();
  wb_reg_bank_if bus3 ();

  wb_reg_bank #(.ACK_DLY(0)) dut0 (.iCLK(clk), .iRST_n(rstN), .bus(bus0), .oREG(reg0));
  wb_reg_bank #(.ACK_DLY(3)) dut3 (.iCLK(clk), .iRST_n(rstN), .bus(bus3), .oREG(reg3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-cycle strobe on bus0; lat is the cycle of the response after the accept cycle, -1 if none.
  task automatic xfer0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w,
                       output logic ack, output logic err, output logic [31:0] rd, output int lat);
    logic seen;
    bus0.iADR = a; bus0.iDAT = d; bus0.iSEL = s; bus0.iWE = w; bus0.iSTB = 1'b1;
    @(posedge clk); #1;
    bus0.iSTB = 1'b0;
    ack = 1'b0; err = 1'b0; rd = '0; lat = -1; seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (!seen && (bus0.oACK || bus0.oERR)) begin
        seen = 1'b1; ack = bus0.oACK; err = bus0.oERR; rd = bus0.oDAT; lat = c;
      end
      @(posedge clk); #1;
    end
  endtask

  // Strobe on bus3 held for 'hold' cycles; counts every response seen.
  task automatic xfer3(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w,
                       input int hold, output int nAck, output int nErr, output logic [31:0] rd, output int lat);
    bus3.iADR = a; bus3.iDAT = d; bus3.iSEL = s; bus3.iWE = w; bus3.iSTB = 1'b1;
    @(posedge clk); #1;
    nAck = 0; nErr = 0; rd = '0; lat = -1;
    for (int c = 1; c <= 14; c++) begin
      if (c >= hold) bus3.iSTB = 1'b0;
      if (bus3.oACK) begin
        if (nAck == 0) begin lat = c; rd = bus3.oDAT; end
        nAck++;
      end
      if (bus3.oERR) nErr++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic        ack, err;
    logic [31:0] rd;
    int          lat, nAck, nErr;

    bus0.iADR = '0; bus0.iDAT = '0; bus0.iSEL = '0; bus0.iWE = 1'b0; bus0.iSTB = 1'b0;
    bus3.iADR = '0; bus3.iDAT = '0; bus3.iSEL = '0; bus3.iWE = 1'b0; bus3.iSTB = 1'b0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    chk("rst_ack", {31'd0, bus0.oACK}, 32'd0);
    chk("rst_err", {31'd0, bus0.oERR}, 32'd0);
    chk("rst_dat", bus0.oDAT, 32'd0);
    chk("rst_reg0", reg0[31:0], 32'd0);

    // ID words
    xfer0(32'h0200_0100, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("id0_ack", {31'd0, ack}, 32'd1);
    chk("id0_lat", 32'(lat), 32'd1);
    chk("id0_dat", rd, 32'h0001_0001);
    xfer0(32'h0200_0104, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("id1_dat", rd, 32'h0001_0002);
    xfer0(32'h0200_0108, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("id2_dat", rd, 32'h0001_0003);
    chk("id2_err", {31'd0, err}, 32'd0);

    // Byte-lane write and readback
    xfer0(32'h0200_010C, 32'hDEAD_BEEF, 4'b0011, 1'b1, ack, err, rd, lat);
    chk("wr_ack", {31'd0, ack}, 32'd1);
    chk("wr_oreg", reg0[31:0], 32'h0000_BEEF);
    xfer0(32'h0200_010C, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("rb_dat", rd, 32'h0000_BEEF);
    xfer0(32'h0200_010C, 32'h1122_3344, 4'b1000, 1'b1, ack, err, rd, lat);
    chk("wr_hi_oreg", reg0[31:0], 32'h1100_BEEF);
    xfer0(32'h0200_0110, 32'hFFFF_FFFF, 4'b0000, 1'b1, ack, err, rd, lat);
    chk("sel0_ack", {31'd0, ack}, 32'd1);
    chk("sel0_oreg", reg0[63:32], 32'd0);

    // Error responses
    xfer0(32'h0200_0104, 32'hFFFF_FFFF, 4'hF, 1'b1, ack, err, rd, lat);
    chk("wr_ro_err", {31'd0, err}, 32'd1);
    chk("wr_ro_ack", {31'd0, ack}, 32'd0);
    xfer0(32'h0200_0104, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("ro_keep", rd, 32'h0001_0002);
    xfer0(32'h0200_0102, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("misal_err", {31'd0, err}, 32'd1);
    chk("misal_dat", rd, 32'd0);
    xfer0(32'h0200_0120, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("unmap_err", {31'd0, err}, 32'd1);
    chk("unmap_lat", 32'(lat), 32'd1);

    // Outside the window
    xfer0(32'h0200_0200, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("miss_ack", {31'd0, ack}, 32'd0);
    chk("miss_err", {31'd0, err}, 32'd0);

    // Ack latency with held strobe
    xfer3(32'h0200_0100, 32'h0, 4'h0, 1'b0, 8, nAck, nErr, rd, lat);
    chk("dly_nack", 32'(nAck), 32'd1);
    chk("dly_nerr", 32'(nErr), 32'd0);
    chk("dly_lat", 32'(lat), 32'd4);
    chk("dly_dat", rd, 32'h0001_0001);
    xfer3(32'h0200_010C, 32'h1234_5678, 4'hF, 1'b1, 1, nAck, nErr, rd, lat);
    chk("dly_wr_oreg", reg3[31:0], 32'h1234_5678);

    // Reset in the middle of WAIT
    bus3.iADR = 32'h0200_0110; bus3.iDAT = 32'hCAFE_F00D; bus3.iSEL = 4'hF; bus3.iWE = 1'b1; bus3.iSTB = 1'b1;
    @(posedge clk); #1;
    bus3.iSTB = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    chk("arst_oreg3", reg3[31:0], 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    nAck = 0; nErr = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus3.oACK) nAck++;
      if (bus3.oERR) nErr++;
      @(posedge clk); #1;
    end
    chk("arst_noack", 32'(nAck + nErr), 32'd0);
    chk("arst_nowr", reg3[63:32], 32'd0);
    chk("arst_oreg0", reg0[31:0], 32'd0);

    // Ack counter word
    for (int i = 0; i < 5; i++) begin
      xfer0(32'h0200_0100, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    end
    xfer0(32'h0200_011C, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
`ifdef WB_REG_BANK_ACCNT_EN
    chk("cnt_a_ack", {31'd0, ack}, 32'd1);
    chk("cnt_a_dat", rd, 32'd5);
    xfer0(32'h0200_011C, 32'h0, 4'h0, 1'b0, ack, err, rd, lat);
    chk("cnt_b_dat", rd, 32'd6);
    xfer0(32'h0200_011C, 32'h1, 4'hF, 1'b1, ack, err, rd, lat);
    chk("cnt_wr_err", {31'd0, err}, 32'd1);
`else
    chk("cnt_off_err", {31'd0, err}, 32'd1);
    chk("cnt_off_dat", rd, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
